// File: rtl/updown_step_ctrl_if.sv
// Bus between the sweep controller and its environment: run control,
// frame pacing, and the 3-bit up/down counter it drives.
interface updown_step_ctrl_if;
  logic       start;
  logic       stop;
  logic       frameTick;
  logic [3:0] divSel;
  logic [2:0] cntValue;
  logic       cntEnable;
  logic       cntReset;
  logic       busy;
  logic       sweepDone;
  logic [7:0] sweepCount;

  modport master (
    output start, stop, frameTick, divSel, cntValue,
    input  cntEnable, cntReset, busy, sweepDone, sweepCount
  );

  modport slave (
    input  start, stop, frameTick, divSel, cntValue,
    output cntEnable, cntReset, busy, sweepDone, sweepCount
  );
endinterface

// File: rtl/updown_step_ctrl.sv
// Up/down sweep controller: paces a 3-bit up/down counter through SWEEPS
// full 0->7->0 sweeps, one step per (divSel+1) frame ticks.
// Optional feature macro: STEP_DWELL_EN (hold DWELL_FRAMES ticks at 7 and 0).
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | clear counter, latch divSel, zero run state
// WAIT  | prescale frame ticks until a step is due
// STEP  | one-cycle cntEnable pulse
// CHECK | inspect the counter's updated value for endpoints
// DWELL | hold at an endpoint for DWELL_FRAMES ticks (STEP_DWELL_EN only)
// DONE  | one-cycle sweepDone pulse
module updown_step_ctrl #(
  parameter int unsigned SWEEPS       = 4,
  parameter int unsigned DWELL_FRAMES = 2
) (
  input logic               clock,
  input logic               reset,
  updown_step_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    WAIT,
    STEP,
    CHECK,
`ifdef STEP_DWELL_EN
    DWELL,
`endif
    DONE
  } state_t;

  localparam logic [7:0] SWEEPS_L = SWEEPS[7:0];

  // Reject illegal parameter values at elaboration.
  if (SWEEPS == 0 || SWEEPS > 255 || DWELL_FRAMES == 0 || DWELL_FRAMES > 15) begin : g_bad_param
    $error("updown_step_ctrl: SWEEPS or DWELL_FRAMES out of range");
  end

  state_t     state;
  logic [3:0] div_lat;
  logic [3:0] presc;
  logic       peak_seen;
  logic [7:0] sweep_cnt;
  logic       cnt_enable_q;
  logic       cnt_reset_q;
  logic       busy_q;
  logic       sweep_done_q;
  logic [7:0] sweep_next;
  logic       endpoint_dwell;

`ifdef STEP_DWELL_EN
  localparam logic [3:0] DWELL_L = DWELL_FRAMES[3:0];
  logic [3:0] dwell_cnt;
  assign endpoint_dwell = 1'b1;
`else
  assign endpoint_dwell = 1'b0;
`endif

  assign sweep_next = sweep_cnt + 8'd1;

  assign bus.cntEnable  = cnt_enable_q;
  assign bus.cntReset   = cnt_reset_q;
  assign bus.busy       = busy_q;
  assign bus.sweepDone  = sweep_done_q;
  assign bus.sweepCount = sweep_cnt;

  // Sequencer: state, run bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      div_lat      <= '0;
      presc        <= '0;
      peak_seen    <= 1'b0;
      sweep_cnt    <= '0;
      cnt_enable_q <= 1'b0;
      cnt_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
`ifdef STEP_DWELL_EN
      dwell_cnt    <= '0;
`endif
    end else begin
      cnt_enable_q <= 1'b0;
      cnt_reset_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      if (bus.stop && state != IDLE) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state       <= CLEAR;
              cnt_reset_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
          CLEAR: begin
            div_lat   <= bus.divSel;
            presc     <= '0;
            peak_seen <= 1'b0;
            sweep_cnt <= '0;
            state     <= WAIT;
          end
          WAIT: begin
            if (bus.frameTick) begin
              if (presc == div_lat) begin
                presc        <= '0;
                state        <= STEP;
                cnt_enable_q <= 1'b1;
              end else begin
                presc <= presc + 4'd1;
              end
            end
          end
          STEP: state <= CHECK;
          CHECK: begin
            state <= WAIT;
            if (bus.cntValue == 3'd7 && !peak_seen) begin
              peak_seen <= 1'b1;
`ifdef STEP_DWELL_EN
              state     <= DWELL;
              dwell_cnt <= DWELL_L;
`endif
            end else if (bus.cntValue == 3'd0 && peak_seen) begin
              peak_seen <= 1'b0;
              sweep_cnt <= sweep_next;
              if (sweep_next == SWEEPS_L) begin
                state        <= DONE;
                sweep_done_q <= 1'b1;
              end else if (endpoint_dwell) begin
`ifdef STEP_DWELL_EN
                state     <= DWELL;
                dwell_cnt <= DWELL_L;
`endif
              end
            end
          end
`ifdef STEP_DWELL_EN
          DWELL: begin
            if (bus.frameTick) begin
              if (dwell_cnt == 4'd1) begin
                state <= WAIT;
                presc <= '0;
              end else begin
                dwell_cnt <= dwell_cnt - 4'd1;
              end
            end
          end
`endif
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Self-checking bench for updown_step_ctrl. Two instances share stimulus:
// dut_a runs single-sweep jobs, dut_b runs three-sweep jobs.
module tb_updown_step_ctrl;

  localparam int DF   = 2;
  localparam int SW_A = 1;
  localparam int SW_B = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       frameTick = 1'b0;
  logic [3:0] divSel = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  updown_step_ctrl_if ia ();
  updown_step_ctrl_if ib ();

  logic [2:0] cva = 3'd0, cvb = 3'd0;
  logic       upa = 1'b1, upb = 1'b1;

  assign ia.start = start;  assign ib.start = start;
  assign ia.stop = stop;    assign ib.stop = stop;
  assign ia.frameTick = frameTick;  assign ib.frameTick = frameTick;
  assign ia.divSel = divSel;  assign ib.divSel = divSel;
  assign ia.cntValue = cva;   assign ib.cntValue = cvb;

  updown_step_ctrl #(.SWEEPS(SW_A), .DWELL_FRAMES(DF)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  updown_step_ctrl #(.SWEEPS(SW_B), .DWELL_FRAMES(DF)) dut_b (.clock(clock), .reset(reset), .bus(ib));

  // Bouncing 3-bit counters driven by each controller.
  always @(posedge clock) begin
    if (ia.cntReset) begin cva <= 3'd0; upa <= 1'b1; end
    else if (ia.cntEnable) begin
      if (upa) begin cva <= cva + 3'd1; if (cva == 3'd6) upa <= 1'b0; end
      else begin cva <= cva - 3'd1; if (cva == 3'd1) upa <= 1'b1; end
    end
    if (ib.cntReset) begin cvb <= 3'd0; upb <= 1'b1; end
    else if (ib.cntEnable) begin
      if (upb) begin cvb <= cvb + 3'd1; if (cvb == 3'd6) upb <= 1'b0; end
      else begin cvb <= cvb - 3'd1; if (cvb == 3'd1) upb <= 1'b1; end
    end
  end

  // Free-running pulse counters sampled mid-cycle.
  int en_a = 0, rs_a = 0, dn_a = 0, en_b = 0, rs_b = 0, dn_b = 0, both_hi = 0;
  always @(negedge clock) begin
    if (ia.cntEnable) en_a <= en_a + 1;
    if (ia.cntReset)  rs_a <= rs_a + 1;
    if (ia.sweepDone) dn_a <= dn_a + 1;
    if (ib.cntEnable) en_b <= en_b + 1;
    if (ib.cntReset)  rs_b <= rs_b + 1;
    if (ib.sweepDone) dn_b <= dn_b + 1;
    if ((ia.cntEnable && ia.cntReset) || (ib.cntEnable && ib.cntReset)) both_hi <= both_hi + 1;
  end

  // Tick-level reference: position in a 14-step triangle sweep.
  int m_div, m_presc, m_pos, m_peak, m_dwell, m_sweeps, m_target, m_steps;
  bit m_done;

  task automatic model_init(input int div, input int target);
    m_div = div; m_presc = 0; m_pos = 0; m_peak = 0; m_dwell = 0;
    m_sweeps = 0; m_target = target; m_steps = 0; m_done = 0;
  endtask

  task automatic model_tick();
    int v;
    if (m_done) return;
    if (m_dwell > 0) begin
      m_dwell--;
      if (m_dwell == 0) m_presc = 0;
      return;
    end
    if (m_presc != m_div) begin m_presc++; return; end
    m_presc = 0;
    m_steps++;
    m_pos = (m_pos + 1) % 14;
    v = (m_pos <= 7) ? m_pos : 14 - m_pos;
    if (v == 7 && m_peak == 0) begin
      m_peak = 1;
`ifdef STEP_DWELL_EN
      m_dwell = DF;
`endif
    end else if (v == 0 && m_peak == 1) begin
      m_peak = 0;
      m_sweeps++;
      if (m_sweeps == m_target) m_done = 1;
      else begin
`ifdef STEP_DWELL_EN
        m_dwell = DF;
`endif
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick(input int gap);
    frameTick = 1'b1; cyc(1); frameTick = 1'b0; cyc(gap - 1);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0; cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; frameTick = 1'b0;
    cyc(2); reset = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0; frameTick = 1'b1; divSel = 4'd5;
    cyc(3);
    checks++;
    if ({ia.cntEnable, ia.cntReset, ia.busy, ia.sweepDone, ia.sweepCount} !== 12'd0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {ia.cntEnable, ia.cntReset, ia.busy, ia.sweepDone, ia.sweepCount});
    end
    checks++;
    if ({ib.cntEnable, ib.cntReset, ib.busy, ib.sweepDone, ib.sweepCount} !== 12'd0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {ib.cntEnable, ib.cntReset, ib.busy, ib.sweepDone, ib.sweepCount});
    end
    start = 1'b0; frameTick = 1'b0; reset = 1'b0; cyc(2);
  endtask

  task automatic test_start_stop();
    int r0;
    do_reset();
    r0 = rs_b;
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0; cyc(2);
    checks++;
    if (ib.busy !== 1'b0 || rs_b != r0) begin
      errors++; $display("FAIL start_and_stop: busy %b clears %0d expected busy 0 clears 0", ib.busy, rs_b - r0);
    end
    pulse_start();
    tick(4);
    pulse_start();
    checks++;
    if (rs_b - r0 != 1 || ib.busy !== 1'b1) begin
      errors++; $display("FAIL start_ignored_in_run: clears %0d busy %b expected 1 and 1", rs_b - r0, ib.busy);
    end
  endtask

  task automatic test_single_sweep();
    int e0, r0, d0, h0;
    do_reset();
    divSel = 4'd0;
    e0 = en_a; r0 = rs_a; d0 = dn_a; h0 = both_hi;
    pulse_start();
    for (int i = 0; i < 60 && dn_a == d0; i++) tick(4);
    cyc(3);
    checks++;
    if (rs_a - r0 != 1) begin errors++; $display("FAIL sweep_clear_cycles: got %0d expected 1", rs_a - r0); end
    checks++;
    if (en_a - e0 != 14) begin errors++; $display("FAIL sweep_steps: got %0d expected 14", en_a - e0); end
    checks++;
    if (dn_a - d0 != 1) begin errors++; $display("FAIL sweep_done_pulses: got %0d expected 1", dn_a - d0); end
    checks++;
    if (ia.sweepCount !== 8'd1) begin errors++; $display("FAIL sweep_count: got %0d expected 1", ia.sweepCount); end
    checks++;
    if (ia.busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_after_done: got %b expected 0", ia.busy); end
    checks++;
    if (both_hi != h0) begin errors++; $display("FAIL enable_reset_overlap: got %0d expected 0", both_hi - h0); end
  endtask

  task automatic test_divider();
    int e0, gap, div;
    for (int r = 0; r < 3; r++) begin
      div = (r == 0) ? 3 : int'($urandom_range(0, 4));
      gap = (r == 0) ? 10 : int'($urandom_range(4, 12));
      do_reset();
      divSel = 4'(div);
      model_init(div, SW_B);
      e0 = en_b;
      pulse_start();
      for (int k = 0; k < 24; k++) begin
        tick(gap);
        model_tick();
        checks++;
        if (en_b - e0 != m_steps) begin
          errors++; $display("FAIL divider_steps div=%0d tick=%0d: got %0d expected %0d", div, k, en_b - e0, m_steps);
        end
      end
      checks++;
      if (ib.sweepCount !== 8'(m_sweeps)) begin
        errors++; $display("FAIL divider_sweeps div=%0d: got %0d expected %0d", div, ib.sweepCount, m_sweeps);
      end
    end
  endtask

  task automatic test_stop();
    int e0, d0;
    do_reset();
    divSel = 4'd0;
    e0 = en_b; d0 = dn_b;
    pulse_start();
    for (int i = 0; i < 4; i++) tick(4);
    frameTick = 1'b1; cyc(1); frameTick = 1'b0;
    stop = 1'b1; cyc(1); stop = 1'b0;
    checks++;
    if (ib.busy !== 1'b0 || ib.cntEnable !== 1'b0) begin
      errors++; $display("FAIL stop_next_edge: busy %b enable %b expected 0 0", ib.busy, ib.cntEnable);
    end
    for (int i = 0; i < 10; i++) tick(4);
    checks++;
    if (en_b - e0 != 5) begin errors++; $display("FAIL stop_steps: got %0d expected 5", en_b - e0); end
    checks++;
    if (dn_b != d0 || ib.sweepCount !== 8'd0) begin
      errors++; $display("FAIL stop_done_count: done %0d count %0d expected 0 0", dn_b - d0, ib.sweepCount);
    end
  endtask

  task automatic test_dwell();
    int e0, quiet, exp_quiet;
    bit stepped;
`ifdef STEP_DWELL_EN
    exp_quiet = DF;
`else
    exp_quiet = 0;
`endif
    do_reset();
    divSel = 4'd0;
    e0 = en_b;
    pulse_start();
    for (int i = 0; i < 7; i++) tick(4);
    checks++;
    if (cvb !== 3'd7 || en_b - e0 != 7) begin
      errors++; $display("FAIL dwell_reach_top: value %0d steps %0d expected 7 7", cvb, en_b - e0);
    end
    quiet = 0; stepped = 0;
    for (int i = 0; i < 8 && !stepped; i++) begin
      tick(4);
      if (en_b - e0 > 7) stepped = 1; else quiet++;
    end
    checks++;
    if (!stepped || quiet != exp_quiet) begin
      errors++; $display("FAIL dwell_quiet_ticks: got %0d (resumed %b) expected %0d", quiet, stepped, exp_quiet);
    end
  endtask

  task automatic test_tick_in_check();
    int e0;
    do_reset();
    divSel = 4'd1;
    e0 = en_b;
    pulse_start();
    tick(4);
    frameTick = 1'b1; cyc(1); frameTick = 1'b0; cyc(1);
    frameTick = 1'b1; cyc(1); frameTick = 1'b0; cyc(3);
    checks++;
    if (en_b - e0 != 1) begin errors++; $display("FAIL check_tick_step: got %0d expected 1", en_b - e0); end
    tick(4);
    checks++;
    if (en_b - e0 != 1) begin errors++; $display("FAIL check_tick_dropped: got %0d expected 1", en_b - e0); end
    frameTick = 1'b1; cyc(2); frameTick = 1'b0; cyc(3);
    checks++;
    if (en_b - e0 != 2) begin errors++; $display("FAIL step_tick_step: got %0d expected 2", en_b - e0); end
    tick(4);
    checks++;
    if (en_b - e0 != 2) begin errors++; $display("FAIL step_tick_dropped: got %0d expected 2", en_b - e0); end
    tick(4);
    checks++;
    if (en_b - e0 != 3) begin errors++; $display("FAIL prescaler_resume: got %0d expected 3", en_b - e0); end
  endtask

  task automatic test_reset_midrun();
    int r0, e0;
    do_reset();
    divSel = 4'd0;
    pulse_start();
    for (int i = 0; i < 100 && ib.sweepCount != 8'd2; i++) tick(4);
    checks++;
    if (ib.sweepCount !== 8'd2 || ib.busy !== 1'b1) begin
      errors++; $display("FAIL midrun_reach_two: count %0d busy %b expected 2 1", ib.sweepCount, ib.busy);
    end
    reset = 1'b1; start = 1'b1; stop = 1'b1; frameTick = 1'b1;
    cyc(1);
    checks++;
    if ({ib.cntEnable, ib.cntReset, ib.busy, ib.sweepDone, ib.sweepCount} !== 12'd0) begin
      errors++; $display("FAIL midrun_reset_outputs: got %h expected 0", {ib.cntEnable, ib.cntReset, ib.busy, ib.sweepDone, ib.sweepCount});
    end
    reset = 1'b0; start = 1'b0; stop = 1'b0; frameTick = 1'b0;
    cyc(2);
    checks++;
    if (ib.busy !== 1'b0) begin errors++; $display("FAIL midrun_idle_after_reset: got %b expected 0", ib.busy); end
    r0 = rs_b; e0 = en_b;
    pulse_start();
    checks++;
    if (rs_b - r0 != 1 || ib.busy !== 1'b1 || cvb !== 3'd0) begin
      errors++; $display("FAIL restart_clear: clears %0d busy %b value %0d expected 1 1 0", rs_b - r0, ib.busy, cvb);
    end
    tick(4);
    checks++;
    if (en_b - e0 != 1 || cvb !== 3'd1) begin
      errors++; $display("FAIL restart_first_step: steps %0d value %0d expected 1 1", en_b - e0, cvb);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_stop();
    test_single_sweep();
    test_divider();
    test_stop();
    test_dwell();
    test_tick_in_check();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_step_ctrl.md
UPDOWN_STEP_CTRL -- requirements
Module: updown_step_ctrl

Interface
REQ-001 The block SHALL have parameter SWEEPS, default 4, number of full 0->7->0 sweeps per run (legal 1..255).
REQ-002 The block SHALL have parameter DWELL_FRAMES, default 2, number of frameTick pulses held at each endpoint (legal 1..15; used only with STEP_DWELL_EN).
REQ-003 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  one-cycle run request.
REQ-006 The block SHALL have port stop  input  1  abort request.
REQ-007 The block SHALL have port frameTick  input  1  one-cycle pacing pulse (one per VGA frame).
REQ-008 The block SHALL have port divSel  input  4  frame-tick divider select, latched at start.
REQ-009 The block SHALL have port cntValue  input  3  current value of the driven 3-bit up/down counter.
REQ-010 The block SHALL have port cntEnable  output  1  one-cycle step pulse to the counter.
REQ-011 The block SHALL have port cntReset  output  1  one-cycle clear pulse to the counter.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port sweepDone  output  1  one-cycle pulse on run completion.
REQ-014 The block SHALL have port sweepCount  output  8  completed sweeps in the current or last run.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, WAIT, STEP, CHECK, DWELL and DONE, with all outputs registered.
REQ-016 IDLE SHALL move to CLEAR on start and SHALL ignore start in every other state.
REQ-017 CLEAR SHALL last 1 cycle, assert cntReset, latch divSel, zero the prescaler, peakSeen and sweepCount, then go to WAIT.
REQ-018 In WAIT, on frameTick, the block SHALL go to STEP and zero the prescaler if prescaler == latched divSel, otherwise increment the prescaler.
REQ-019 divSel=0 SHALL step on every frameTick, and divSel=N SHALL step on every (N+1)th frameTick.
REQ-020 STEP SHALL last 1 cycle, assert cntEnable, then go to CHECK.
REQ-021 CHECK SHALL sample cntValue, one cycle after cntEnable, to match the counter's registered update.
REQ-022 In CHECK, cntValue==7 with peakSeen=0 SHALL set peakSeen, then go to DWELL if STEP_DWELL_EN is defined, else to WAIT.
REQ-023 In CHECK, cntValue==0 with peakSeen=1 SHALL clear peakSeen and increment sweepCount; if the new count equals SWEEPS, next state SHALL be DONE, else DWELL (with STEP_DWELL_EN) or WAIT.
REQ-024 In CHECK, any other value SHALL return the FSM to WAIT.
REQ-025 A frameTick arriving in STEP or CHECK SHALL be dropped and SHALL NOT advance the prescaler.
REQ-026 DONE SHALL last 1 cycle, assert sweepDone, then go to IDLE; sweepCount SHALL hold its value until the next CLEAR.
REQ-027 stop in any non-IDLE state SHALL force IDLE on the next edge, with no cntEnable, no sweepDone, and sweepCount held.
REQ-028 stop SHALL take priority over frameTick and state transitions, and stop in IDLE SHALL have no effect.
REQ-029 start and stop asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-030 cntEnable and cntReset SHALL never be high in the same cycle.

Reset
REQ-031 On a clock edge with reset=1, the FSM SHALL enter IDLE, and prescaler, dwell counter, peakSeen and sweepCount SHALL go to 0.
REQ-032 During reset, cntEnable, cntReset, busy and sweepDone SHALL be 0.
REQ-033 reset SHALL take priority over stop, start and frameTick, including in the middle of a run.

Configuration
REQ-034 When macro STEP_DWELL_EN is defined, the DWELL state SHALL count DWELL_FRAMES frameTicks at each endpoint (7 and 0), then go to WAIT with the prescaler zeroed.
REQ-035 When STEP_DWELL_EN is undefined, the DWELL state and its counter SHALL be absent, CHECK SHALL go directly to WAIT, and DWELL_FRAMES SHALL be ignored.

Verification
REQ-036 The bench SHALL check: reset, then start with divSel=0 and SWEEPS=1 -> cntReset for 1 cycle, 14 cntEnable pulses, sweepDone once, sweepCount=1, busy low after DONE.
REQ-037 The bench SHALL check: divSel=3 with frameTick every 10 cycles -> cntEnable on every 4th frameTick only.
REQ-038 The bench SHALL check: stop asserted after the 5th cntEnable -> IDLE next edge, no further cntEnable, no sweepDone, sweepCount=0.
REQ-039 The bench SHALL check: STEP_DWELL_EN defined, DWELL_FRAMES=2, divSel=0 -> after the counter reaches 7, 2 frameTicks with no cntEnable before stepping resumes.
REQ-040 The bench SHALL check: frameTick coincident with the CHECK cycle -> tick ignored, prescaler unchanged.
REQ-041 The bench SHALL check: reset pulsed mid-run with sweepCount=2 -> all outputs 0 next edge, and start restarts cleanly with cntReset.
